// File: rtl/datamem_pkg.sv
// rtl/datamem_pkg.sv - shared types, read-latency limits and lane merge helper for datamem_pipe
package datamem_pkg;

  typedef enum logic {
    DM_CLEAR = 1'b0,
    DM_READY = 1'b1
  } dm_state_t;

  localparam int DM_RD_LAT_MIN = 1;
  localparam int DM_RD_LAT_MAX = 2;

  // One byte lane: take the new byte when its enable is set, else keep the old one.
  function automatic logic [7:0] be_merge(input logic [7:0] old_b,
                                          input logic [7:0] new_b,
                                          input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/datamem_array.sv
// rtl/datamem_array.sv - plain storage array: byte-enabled write port, registered read port
module datamem_array
  import datamem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Read returns the pre-write contents; the top level supplies write-first bypass.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/datamem_pipe.sv
// rtl/datamem_pipe.sv - data memory with zero-fill sweep, write-first bypass and pipelined reads
module datamem_pipe
  import datamem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  ready,
  input  logic                  EN,
  input  logic [ADDR_W-1:0]     write_addr,
  input  logic [DATA_W-1:0]     write_data,
  input  logic [DATA_W/8-1:0]   write_be,
  input  logic                  rd_req,
  input  logic [ADDR_W-1:0]     read_addr,
  output logic [DATA_W-1:0]     read_data,
  output logic                  rd_valid
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2**ADDR_W;

  dm_state_t         state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic              clearing;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic [NB-1:0]     arr_wbe;
  logic              rd_acc;
  logic [DATA_W-1:0] arr_rdata;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_seen_q, s1_seen_d;
  logic [NB-1:0]     byp_be_q, byp_be_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d;
  logic [DATA_W-1:0] s1_data;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      DM_CLEAR: begin
        if (clr) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + (ADDR_W+1)'(1);
          if (ptr_d == (ADDR_W+1)'(DEPTH)) begin
            state_d = DM_READY;
            ptr_d   = '0;
          end
        end
      end
      DM_READY: begin
        if (clr) begin
          state_d = DM_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = DM_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign clearing = (state_q == DM_CLEAR);
  assign ready    = (state_q == DM_READY);

  always_comb begin
    arr_we    = clearing | EN;
    arr_waddr = clearing ? ptr_q[ADDR_W-1:0] : write_addr;
    arr_wdata = clearing ? '0 : write_data;
    arr_wbe   = clearing ? '1 : write_be;
    rd_acc    = ready & rd_req & ~clr;
  end

  // Bypass state is only refreshed on an accepted read so read_data holds between results.
  always_comb begin
    s1_valid_d = rd_acc;
    s1_seen_d  = s1_seen_q;
    byp_be_d   = byp_be_q;
    byp_data_d = byp_data_q;
    if (rd_acc) begin
      s1_seen_d  = 1'b1;
      byp_be_d   = (EN && (write_addr == read_addr)) ? write_be : '0;
      byp_data_d = write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DM_CLEAR;
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_seen_q  <= 1'b0;
      byp_be_q   <= '0;
      byp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_seen_q  <= s1_seen_d;
      byp_be_q   <= byp_be_d;
      byp_data_q <= byp_data_d;
    end
  end

  datamem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .wbe   (arr_wbe),
    .re    (rd_acc),
    .raddr (read_addr),
    .rdata (arr_rdata)
  );

  // The RAM output register has no reset, so it is masked until the first read after reset.
  always_comb begin
    s1_data = '0;
    for (int i = 0; i < NB; i++) begin
      s1_data[8*i +: 8] = be_merge(arr_rdata[8*i +: 8], byp_data_q[8*i +: 8], byp_be_q[i]);
    end
    if (!s1_seen_q) s1_data = '0;
  end

  if (RD_LAT == DM_RD_LAT_MAX) begin : g_out_reg
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    always_comb begin
      out_valid_d = s1_valid_q;
      out_data_d  = s1_valid_q ? s1_data : out_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        out_valid_q <= out_valid_d;
        out_data_q  <= out_data_d;
      end
    end

    assign rd_valid  = out_valid_q;
    assign read_data = out_data_q;
  end else begin : g_no_out_reg
    assign rd_valid  = s1_valid_q;
    assign read_data = s1_data;
  end

endmodule

// File: tb/tb_datamem_pipe.sv
// tb/tb_datamem_pipe.sv - scoreboard bench driving RD_LAT=1 and RD_LAT=2 instances in lockstep
module tb_datamem_pipe;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          en = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [AW-1:0] raddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [BW-1:0] wbe = '0;

  logic          ready1, ready2, valid1, valid2;
  logic [DW-1:0] rdata1, rdata2;

  always #5 clk = ~clk;

  datamem_pipe #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready1), .EN(en),
    .write_addr(waddr), .write_data(wdata), .write_be(wbe),
    .rd_req(rd_req), .read_addr(raddr), .read_data(rdata1), .rd_valid(valid1)
  );

  datamem_pipe #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready2), .EN(en),
    .write_addr(waddr), .write_data(wdata), .write_be(wbe),
    .rd_req(rd_req), .read_addr(raddr), .read_data(rdata2), .rd_valid(valid2)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q1[$];
  exp_t          q2[$];
  logic [DW-1:0] mem_m [256];
  logic          m_ready = 1'b0;
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Scoreboard: each result must arrive on its due cycle carrying the modelled data.
  always @(negedge clk) begin
    exp_t e;
    if (valid1) begin
      if (q1.size() == 0) chk("rd1_unexpected_valid", 32'(valid1), 32'd0);
      else begin
        e = q1.pop_front();
        chk("rd1_data", rdata1, e.data);
        chk("rd1_cycle", 32'(cyc), 32'(e.due));
      end
    end else if (q1.size() != 0 && q1[0].due <= cyc) begin
      chk("rd1_missing_valid", 32'(valid1), 32'd1);
      void'(q1.pop_front());
    end
    if (valid2) begin
      if (q2.size() == 0) chk("rd2_unexpected_valid", 32'(valid2), 32'd0);
      else begin
        e = q2.pop_front();
        chk("rd2_data", rdata2, e.data);
        chk("rd2_cycle", 32'(cyc), 32'(e.due));
      end
    end else if (q2.size() != 0 && q2[0].due <= cyc) begin
      chk("rd2_missing_valid", 32'(valid2), 32'd1);
      void'(q2.pop_front());
    end
  end

  task automatic step(input logic e, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [BW-1:0] be, input logic rq, input logic [AW-1:0] ra,
                      input logic c);
    exp_t x;
    en = e; waddr = wa; wdata = wd; wbe = be; rd_req = rq; raddr = ra; clr = c;
    if (m_ready) begin
      if (rq && !c) begin
        x.data = (e && wa == ra) ? merge(mem_m[ra], wd, be) : mem_m[ra];
        x.due  = cyc + 1;
        q1.push_back(x);
        x.due  = cyc + 2;
        q2.push_back(x);
      end
      if (e) mem_m[wa] = merge(mem_m[wa], wd, be);
      if (c) m_ready = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    step(1'b1, a, d, be, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, '0, '0, '0, 1'b1, a, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  // 256-edge sweep with ignored traffic; ready must rise exactly on the last edge.
  task automatic sweep_wait();
    for (int i = 0; i < 255; i++) begin
      step(1'b1, AW'($urandom), $urandom, BW'($urandom), 1'b1, AW'($urandom), 1'b0);
      chk("sweep_no_valid1", 32'(valid1), 32'd0);
      chk("sweep_no_valid2", 32'(valid2), 32'd0);
    end
    chk("sweep_ready1_low_cycle256", 32'(ready1), 32'd0);
    chk("sweep_ready2_low_cycle256", 32'(ready2), 32'd0);
    step(1'b1, AW'($urandom), $urandom, BW'($urandom), 1'b1, AW'($urandom), 1'b0);
    chk("sweep_ready1_high_cycle257", 32'(ready1), 32'd1);
    chk("sweep_ready2_high_cycle257", 32'(ready2), 32'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem_m[i] = '0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_ready1", 32'(ready1), 32'd0);
    chk("reset_ready2", 32'(ready2), 32'd0);
    chk("reset_valid1", 32'(valid1), 32'd0);
    chk("reset_valid2", 32'(valid2), 32'd0);
    chk("reset_data1", rdata1, 32'd0);
    chk("reset_data2", rdata2, 32'd0);
    rst_n = 1'b1;
    sweep_wait();

    // Byte enables, including an EN with no lanes set
    wr(8'd5, 32'hAABBCCDD, 4'hF);
    wr(8'd5, 32'h11223344, 4'b0101);
    wr(8'd5, 32'hFFFFFFFF, 4'b0000);
    rd(8'd5);
    idle(); idle();

    // Latency and throughput
    wr(8'd1, 32'h01010101, 4'hF);
    wr(8'd2, 32'h02020202, 4'hF);
    wr(8'd3, 32'h03030303, 4'hF);
    rd(8'd1);
    chk("lat1_valid_e1", 32'(valid1), 32'd1);
    chk("lat2_valid_e1", 32'(valid2), 32'd0);
    rd(8'd2);
    chk("lat2_valid_e2", 32'(valid2), 32'd1);
    rd(8'd3);
    chk("lat2_valid_e3", 32'(valid2), 32'd1);
    idle();
    chk("lat2_valid_e4", 32'(valid2), 32'd1);
    chk("lat1_valid_e4", 32'(valid1), 32'd0);
    idle();
    chk("lat2_valid_e5", 32'(valid2), 32'd0);
    chk("lat2_hold_data", rdata2, 32'h03030303);

    // Write-first collisions
    wr(8'd9, 32'h0000000F, 4'hF);
    step(1'b1, 8'd9, 32'h000000F0, 4'b0001, 1'b1, 8'd9, 1'b0);
    wr(8'd10, 32'h12345678, 4'hF);
    step(1'b1, 8'd10, 32'hAABBCCDD, 4'b0110, 1'b1, 8'd10, 1'b0);
    step(1'b1, 8'd11, 32'h99999999, 4'hF, 1'b1, 8'd10, 1'b0);
    rd(8'd9);
    idle(); idle();

    // Clear while a read is in flight, then restart the sweep mid-way
    wr(8'd20, 32'hDEADBEEF, 4'hF);
    rd(8'd20);
    step(1'b0, '0, '0, '0, 1'b1, 8'd20, 1'b1);
    chk("clr_ready1_drop", 32'(ready1), 32'd0);
    chk("clr_ready2_drop", 32'(ready2), 32'd0);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, AW'($urandom), $urandom, BW'($urandom), 1'b1, AW'($urandom), 1'b0);
      chk("clr_no_valid1", 32'(valid1), 32'd0);
      if (i >= 1) chk("clr_no_valid2", 32'(valid2), 32'd0);
    end
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    sweep_wait();
    rd(8'd20); rd(8'd0); rd(8'd255); rd(8'd5);
    idle(); idle();

    // Preload, then async reset during a read
    wr(8'h00, 32'hCAFEF00D, 4'hF);
    wr(8'h7F, 32'h7F7F7F7F, 4'hF);
    wr(8'hFF, 32'hFEEDFACE, 4'hF);
    wr(8'd30, 32'h5A5A5A5A, 4'hF);
    rd(8'h00); rd(8'h7F); rd(8'hFF);
    idle(); idle();
    rd(8'd30);
    rd(8'd30);
    chk("pre_reset_valid1", 32'(valid1), 32'd1);
    chk("pre_reset_valid2", 32'(valid2), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid1", 32'(valid1), 32'd0);
    chk("async_valid2", 32'(valid2), 32'd0);
    chk("async_data1", rdata1, 32'd0);
    chk("async_data2", rdata2, 32'd0);
    chk("async_ready1", 32'(ready1), 32'd0);
    q1.delete();
    q2.delete();
    m_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sweep_wait();
    rd(8'h00); rd(8'h7F); rd(8'hFF);
    idle(); idle(); idle();
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/datamem_pipe.md
# datamem_pipe

Parametrised data memory for the TISC datapath: the successor to the current 8-bit × 256 data store. It adds configurable width and depth, byte-lane write enables, and a pipelined read port with a valid strobe. It also performs a hardware zero-fill sweep after reset or on request, so contents are defined without a preload file. It sits between the execute stage's load/store unit and the storage array.

## Interface
- `DATA_W`, 8: word width in bits; must be a multiple of 8.
- `ADDR_W`, 8: address width; depth is 2**ADDR_W words.
- `RD_LAT`, 1: read latency in cycles; legal values are 1 or 2.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous request to restart the zero-fill sweep.
- `ready`  out  1  high when the memory accepts reads and writes.
- `EN`  in  1  write enable.
- `write_addr`  in  ADDR_W  write word address.
- `write_data`  in  DATA_W  write data.
- `write_be`  in  DATA_W/8  byte-lane enables; bit i covers bits [8i+7:8i].
- `rd_req`  in  1  read request.
- `read_addr`  in  ADDR_W  read word address.
- `read_data`  out  DATA_W  read data; valid only while `rd_valid` is high.
- `rd_valid`  out  1  read data strobe.

## Operation
- The state machine has two states, CLEAR and READY.
  - CLEAR: a sweep counter `ptr` writes all-zero words to address 0 .. 2**ADDR_W−1, one word per cycle. After the last address it moves to READY.
  - READY: normal operation. `clr` high moves it to CLEAR with `ptr` set to 0.
- Asserting `rst_n` low forces CLEAR, sets `ptr` to 0 and flushes the read pipeline. The sweep starts on the first rising edge after `rst_n` deasserts.
- `ready` equals (state == READY).
- In CLEAR, `EN` and `rd_req` are ignored: no write occurs and no `rd_valid` is produced. The sweep takes 2**ADDR_W cycles.
- Write: when `ready` and `EN` are high, each lane with its `write_be` bit set is updated at the clock edge. Other lanes keep their old value. `EN` with `write_be` = 0 is a no-op.
- Read: a request is accepted when `ready` and `rd_req` are high. The array value at `read_addr` is captured into stage 1.
- Read during write to the same address in the same cycle is write-first: returned lanes with `write_be` set carry `write_data`, and the other lanes carry the old contents.
- `clr` arriving while a read is in the pipeline does not cancel that read; it still completes with its captured data. Reads requested in the `clr` cycle are dropped.
- `clr` during CLEAR restarts the sweep at address 0.
- Address arithmetic is unsigned. `ptr` is ADDR_W+1 bits wide so the terminal count can be detected; there is no wrap-around.

## Timing
- Reset values: `ready`=0, `rd_valid`=0, `read_data`=0, state=CLEAR, `ptr`=0.
- The sweep occupies cycles 1 .. 2**ADDR_W after reset deassertion. `ready` rises on the edge that writes the last address; for ADDR_W=8 it is first high in cycle 257.
- With RD_LAT=1, a request accepted at edge N gives `rd_valid`=1 and data from edge N to edge N+1.
- With RD_LAT=2, an output register is added and the data appears one cycle later.
- Back-to-back requests give one result per cycle; there is no backpressure.
- `read_data` holds its last value while `rd_valid` is 0.

## Structure
- Package `datamem_pkg` holds:
  - the state enum `dm_state_t` {DM_CLEAR, DM_READY};
  - the legal `RD_LAT` values;
  - the function `be_merge(old, new, be)`.
- Sub-module `datamem_array`: the plain storage array, with one write port carrying byte enables and one synchronous read port. This is the only inferred RAM.
- The top level holds the sweep FSM, the write-first bypass and the read pipeline.

## Test plan
- Reset and sweep: preload nonzero values, pulse `rst_n` low, wait. `ready` rises in cycle 257. Reads of addresses 0x00, 0x7F and 0xFF return 0x00.
- Byte enables (DATA_W=32): write 0xAABBCCDD with be=4'hF to address 5, then write 0x11223344 with be=4'b0101. A read of address 5 returns 0xAA22CC44.
- Read latency and throughput: with RD_LAT=2, request addresses 1, 2 and 3 on consecutive cycles. `rd_valid` is high for three consecutive cycles starting 2 cycles after the first request, and the data arrives in request order.
- Write-first collision: address 9 holds 0x0F. In one cycle write 0xF0 (be=1) and read address 9. The read returns 0xF0.
- Clear mid-operation: request a read, assert `clr` on the next cycle.
  - The in-flight read completes with the old data.
  - `ready` drops, and no `rd_valid` appears for requests during CLEAR.
  - The sweep completes, and all reads after it return 0.
- Async reset mid-read: drop `rst_n` between edges. `rd_valid` and `read_data` go to 0 immediately, without waiting for a clock edge.
